// File: rtl/knn_topk_core_pkg.sv
// Shared types and width helpers for the k-nearest-neighbour top-K core.
// The distance-width helper keeps the core and its wrapper register map in agreement.
package knn_topk_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Wide enough for the sum of DIM_N squared (DATA_W+1)-bit differences.
    function automatic int dist_width(input int data_w, input int dim_n);
        return 2 * data_w + 2 + ((dim_n > 1) ? $clog2(dim_n) : 0);
    endfunction

endpackage

// File: rtl/knn_topk_core_dist.sv
// Distance stage: squared Euclidean distance between a training point and the
// latched test point, registered together with the label and a valid flag.
module knn_topk_core_dist
    import knn_topk_core_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DIM_N   = 2,
    parameter int LABEL_W = 8,
    parameter int DIST_W  = dist_width(DATA_W, DIM_N)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_clear,
    input  logic                      i_valid,
    input  logic [DIM_N*DATA_W-1:0]   i_test_pt,
    input  logic [DIM_N*DATA_W-1:0]   i_pt,
    input  logic [LABEL_W-1:0]        i_label,
    output logic                      o_valid,
    output logic [DIST_W-1:0]         o_dist,
    output logic [LABEL_W-1:0]        o_label
);

    localparam int SQ_W = 2 * DATA_W + 2;

    logic [SQ_W-1:0]   w_sq [DIM_N];
    logic [DIST_W-1:0] w_sum;

    logic              r_valid;
    logic [DIST_W-1:0] r_dist;
    logic [LABEL_W-1:0] r_label;

    for (genvar d = 0; d < DIM_N; d++) begin : g_dim
        logic signed [DATA_W:0] w_pt_x;
        logic signed [DATA_W:0] w_tp_x;
        logic signed [DATA_W:0] w_diff;
        logic        [DATA_W:0] w_mag;

        // One extra bit makes the difference exact for any pair of DATA_W inputs.
        assign w_pt_x = {i_pt[d*DATA_W+DATA_W-1], i_pt[d*DATA_W +: DATA_W]};
        assign w_tp_x = {i_test_pt[d*DATA_W+DATA_W-1], i_test_pt[d*DATA_W +: DATA_W]};
        assign w_diff = w_pt_x - w_tp_x;
        assign w_mag  = w_diff[DATA_W] ? unsigned'(-w_diff) : unsigned'(w_diff);
        assign w_sq[d] = SQ_W'(w_mag) * SQ_W'(w_mag);
    end

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_sum = '0;
        for (int d = 0; d < DIM_N; d++) begin
            w_sum = w_sum + DIST_W'(w_sq[d]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_dist  <= '0;
            r_label <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_dist  <= '0;
            r_label <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_dist  <= w_sum;
                r_label <= i_label;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_dist  = r_dist;
    assign o_label = r_label;

endmodule

// File: rtl/knn_topk_core.sv
// Top-K nearest-neighbour core: query FSM, distance stage and a sorted,
// stable insertion list of the K smallest distances with their labels.
module knn_topk_core
    import knn_topk_core_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int DIM_N   = 2,
    parameter  int K       = 4,
    parameter  int LABEL_W = 8,
    localparam int DIST_W  = dist_width(DATA_W, DIM_N),
    localparam int CNT_W   = $clog2(K + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      start,
    input  logic [DIM_N*DATA_W-1:0]   test_pt,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIM_N*DATA_W-1:0]   in_pt,
    input  logic [LABEL_W-1:0]        in_label,
    input  logic                      in_last,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          nn_count,
    output logic [K*DIST_W-1:0]       nn_dist,
    output logic [K*LABEL_W-1:0]      nn_label
);

    state_e r_state;
    state_e w_next_state;

    logic [DIM_N*DATA_W-1:0] r_test_pt;
    logic                    w_beat;
    logic                    w_s1_valid;
    logic [DIST_W-1:0]       w_s1_dist;
    logic [LABEL_W-1:0]      w_s1_label;
    logic                    r_s2_valid;

    logic [DIST_W-1:0]  r_nn_dist  [K];
    logic [LABEL_W-1:0] r_nn_label [K];
    logic [CNT_W-1:0]   r_nn_count;

    logic [CNT_W-1:0]   w_pos;
    logic [DIST_W-1:0]  w_ins_dist  [K];
    logic [LABEL_W-1:0] w_ins_label [K];
    logic               w_list_init;

    assign w_beat      = in_valid && (r_state == ST_RUN);
    assign w_list_init = (r_state == ST_IDLE) && start;

    knn_topk_core_dist #(
        .DATA_W  (DATA_W),
        .DIM_N   (DIM_N),
        .LABEL_W (LABEL_W),
        .DIST_W  (DIST_W)
    ) u_dist (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (clear),
        .i_valid   (w_beat),
        .i_test_pt (r_test_pt),
        .i_pt      (in_pt),
        .i_label   (in_label),
        .o_valid   (w_s1_valid),
        .o_dist    (w_s1_dist),
        .o_label   (w_s1_label)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_s2_valid <= 1'b0;
            r_test_pt  <= '0;
        end else if (clear) begin
            r_state    <= ST_IDLE;
            r_s2_valid <= 1'b0;
            r_test_pt  <= '0;
        end else begin
            r_state    <= w_next_state;
            r_s2_valid <= w_s1_valid;
            if (w_list_init) begin
                r_test_pt <= test_pt;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                in_ready = 1'b1;
                if (in_valid && in_last) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!w_s1_valid && !r_s2_valid) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Insertion point counts valid entries not farther than the newcomer, so ties stay in arrival order.
    always_comb begin
        w_pos = '0;
        for (int i = 0; i < K; i++) begin
            if ((CNT_W'(i) < r_nn_count) && (r_nn_dist[i] <= w_s1_dist)) begin
                w_pos = w_pos + CNT_W'(1);
            end
        end
        for (int i = 0; i < K; i++) begin
            w_ins_dist[i]  = r_nn_dist[i];
            w_ins_label[i] = r_nn_label[i];
            if (CNT_W'(i) == w_pos) begin
                w_ins_dist[i]  = w_s1_dist;
                w_ins_label[i] = w_s1_label;
            end else if (CNT_W'(i) > w_pos) begin
                w_ins_dist[i]  = r_nn_dist[(i > 0) ? i - 1 : 0];
                w_ins_label[i] = r_nn_label[(i > 0) ? i - 1 : 0];
            end
        end
    end

    // NOTE: the result list is architecturally visible, so every entry is reset rather than left as storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nn_count <= '0;
            for (int i = 0; i < K; i++) begin
                r_nn_dist[i]  <= '1;
                r_nn_label[i] <= '0;
            end
        end else if (clear || w_list_init) begin
            r_nn_count <= '0;
            for (int i = 0; i < K; i++) begin
                r_nn_dist[i]  <= '1;
                r_nn_label[i] <= '0;
            end
        end else if (w_s1_valid && (w_pos != CNT_W'(K))) begin
            for (int i = 0; i < K; i++) begin
                r_nn_dist[i]  <= w_ins_dist[i];
                r_nn_label[i] <= w_ins_label[i];
            end
            if (r_nn_count != CNT_W'(K)) begin
                r_nn_count <= r_nn_count + CNT_W'(1);
            end
        end
    end

    assign nn_count = r_nn_count;
    for (genvar i = 0; i < K; i++) begin : g_pack
        assign nn_dist[i*DIST_W +: DIST_W]    = r_nn_dist[i];
        assign nn_label[i*LABEL_W +: LABEL_W] = r_nn_label[i];
    end

endmodule
